// File: rtl/karatsuba_pkg.sv
// Shared constants, FSM state type and middle-term correction for the Karatsuba multiplier.
package karatsuba_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    MUL_HI,
    MUL_MID,
    COMBINE,
    DONE
  } kmul_state_t;

  // Restores the full (sa*sb) product from the 16x16 core result plus the dropped sum carries.
  function automatic logic [2*HALF_W+1:0] kmul_mid(
    input logic [2*HALF_W-1:0] m,
    input logic [HALF_W-1:0]   sa16,
    input logic [HALF_W-1:0]   sb16,
    input logic                ca,
    input logic                cb
  );
    logic [2*HALF_W+1:0] r;
    r = {2'b00, m}
      + ({18'd0, (ca ? sb16 : 16'h0000)} << 16)
      + ({18'd0, (cb ? sa16 : 16'h0000)} << 16)
      + ({33'd0, (ca & cb)} << 32);
    return r;
  endfunction

endpackage

// File: rtl/karatsuba_seq_mul32_wallace_tree.sv
// Combinational 16x16 unsigned multiplier core (module wallace_tree): carry-save reduction
// of the partial products followed by a single carry-propagate add.
module wallace_tree
  import karatsuba_pkg::*;
(
  input  logic [HALF_W-1:0]   a_i,
  input  logic [HALF_W-1:0]   b_i,
  output logic [2*HALF_W-1:0] p_o
);

  logic [2*HALF_W-1:0] sumRow;
  logic [2*HALF_W-1:0] carryRow;
  logic [2*HALF_W-1:0] pp;
  logic [2*HALF_W-1:0] t;

  always_comb begin
    sumRow   = '0;
    carryRow = '0;
    pp       = '0;
    t        = '0;
    for (int i = 0; i < HALF_W; i++) begin
      pp       = {16'd0, (b_i & {HALF_W{a_i[i]}})} << i;
      t        = sumRow ^ carryRow ^ pp;
      carryRow = ((sumRow & carryRow) | (sumRow & pp) | (carryRow & pp)) << 1;
      sumRow   = t;
    end
    p_o = sumRow + carryRow;
  end

endmodule

// File: rtl/karatsuba_seq_mul32.sv
// Sequential 32x32 Karatsuba multiplier sharing one 16x16 core over three passes.
// Optional KARATSUBA_CORE_REG_EN registers the core output (two cycles per MUL state).
module karatsuba_seq_mul32
  import karatsuba_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FULL_W-1:0]   a,
  input  logic [FULL_W-1:0]   b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*FULL_W-1:0] y
);

  kmul_state_t state_q, state_d;

  logic [FULL_W-1:0]   a_q, b_q;
  logic [2*HALF_W-1:0] z0_q, z2_q, m_q;
  logic [2*FULL_W-1:0] y_q;

  logic [HALF_W-1:0]   coreA, coreB;
  logic [2*HALF_W-1:0] coreP, coreRes;
  logic                capture;

  logic [HALF_W:0]     sa, sb;
  logic [2*HALF_W+1:0] mid, z1;
  logic [2*FULL_W-1:0] yNext;

  wallace_tree u_core (
    .a_i (coreA),
    .b_i (coreB),
    .p_o (coreP)
  );

`ifdef KARATSUBA_CORE_REG_EN
  logic                phase_q, phase_d;
  logic [2*HALF_W-1:0] core_q;

  // Phase 0 issues operands into the core register, phase 1 captures its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      core_q  <= '0;
    end else begin
      phase_q <= phase_d;
      core_q  <= coreP;
    end
  end

  always_comb begin
    phase_d = 1'b0;
    if (state_q == MUL_LO || state_q == MUL_HI || state_q == MUL_MID)
      phase_d = ~phase_q;
  end

  assign capture = phase_q;
  assign coreRes = core_q;
`else
  assign capture = 1'b1;
  assign coreRes = coreP;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = MUL_LO;
      MUL_LO:  if (capture)   state_d = MUL_HI;
      MUL_HI:  if (capture)   state_d = MUL_MID;
      MUL_MID: if (capture)   state_d = COMBINE;
      COMBINE:                state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    coreA     = '0;
    coreB     = '0;
    unique case (state_q)
      MUL_LO:  begin coreA = a_q[HALF_W-1:0];      coreB = b_q[HALF_W-1:0];      end
      MUL_HI:  begin coreA = a_q[FULL_W-1:HALF_W]; coreB = b_q[FULL_W-1:HALF_W]; end
      MUL_MID: begin coreA = sa[HALF_W-1:0];       coreB = sb[HALF_W-1:0];       end
      default: ;
    endcase
  end

  assign sa = {1'b0, a_q[HALF_W-1:0]} + {1'b0, a_q[FULL_W-1:HALF_W]};
  assign sb = {1'b0, b_q[HALF_W-1:0]} + {1'b0, b_q[FULL_W-1:HALF_W]};

  // z1 = mid - z0 - z2 is never negative, so 34-bit modular arithmetic is exact.
  assign mid   = kmul_mid(m_q, sa[HALF_W-1:0], sb[HALF_W-1:0], sa[HALF_W], sb[HALF_W]);
  assign z1    = mid - {2'b00, z0_q} - {2'b00, z2_q};
  assign yNext = {z2_q, 32'd0} + ({30'd0, z1} << 16) + {32'd0, z0_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      z0_q <= '0;
      z2_q <= '0;
      m_q  <= '0;
      y_q  <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      if (state_q == MUL_LO  && capture) z0_q <= coreRes;
      if (state_q == MUL_HI  && capture) z2_q <= coreRes;
      if (state_q == MUL_MID && capture) m_q  <= coreRes;
      if (state_q == COMBINE)            y_q  <= yNext;
    end
  end

  assign y = y_q;

endmodule
